// File: rtl/rr_mux4_pkg.sv
// rtl/rr_mux4_pkg.sv - shared types, sizes and round-robin pick helper for the 4-way arbiter
package rr_mux4_pkg;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 4;
   localparam int BEAT_W  = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Returns {found, index}; the search starts just after 'last' and wraps, so 'last' itself is tried last.
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                              input logic [SEL_W-1:0]   last);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + SEL_W'(k);
         if (req_vec[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux4to1.sv
// rtl/mux4to1.sv - 4-bit 4:1 data multiplexer selected by {s1,s0}
module mux4to1
   import rr_mux4_pkg::*;
(
   input  logic              s1,
   input  logic              s0,
   input  logic [DATA_W-1:0] i0,
   input  logic [DATA_W-1:0] i1,
   input  logic [DATA_W-1:0] i2,
   input  logic [DATA_W-1:0] i3,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = i0;
      case ({s1, s0})
         2'b00:   y = i0;
         2'b01:   y = i1;
         2'b10:   y = i2;
         default: y = i3;
      endcase
   end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - 4-requester round-robin arbiter with burst limit driving a 4:1 data mux
module rr_mux4_arbiter
   import rr_mux4_pkg::*;
#(
   parameter int MAX_BEATS = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [DATA_W-1:0]  i0,
   input  logic [DATA_W-1:0]  i1,
   input  logic [DATA_W-1:0]  i2,
   input  logic [DATA_W-1:0]  i3,
   input  logic               rdy,
   output logic [DATA_W-1:0]  y,
   output logic               valid,
   output logic [NUM_REQ-1:0] gnt,
   output logic               s1,
   output logic               s0,
   output logic [NUM_REQ-1:0] ack
);

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [SEL_W-1:0]   r_sel;
   logic [BEAT_W-1:0]  r_beats;
   logic [SEL_W-1:0]   r_last;

   state_t             w_state_nxt;
   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [BEAT_W-1:0]  w_beats_nxt;
   logic [SEL_W-1:0]   w_last_nxt;

   logic               w_req_g;
   logic               w_xfer;
   logic [BEAT_W-1:0]  w_beats_inc;
   logic [SEL_W-1:0]   w_base;
   logic [SEL_W:0]     w_pick;
   logic [NUM_REQ-1:0] w_pick_onehot;
   logic               w_rearb;
   logic [DATA_W-1:0]  w_mux_y;

   assign w_req_g     = req[r_sel];
   assign valid       = !rst && (r_state == ST_GRANT) && w_req_g;
   assign w_xfer      = valid && rdy;
   assign ack         = r_gnt & {NUM_REQ{w_xfer}};
   assign w_beats_inc = r_beats + BEAT_W'(1);

   // In IDLE the search follows the last served requester; in GRANT the current holder counts as served.
   assign w_base        = (r_state == ST_IDLE) ? r_last : r_sel;
   assign w_pick        = rr_pick(req, w_base);
   assign w_pick_onehot = NUM_REQ'(1) << w_pick[SEL_W-1:0];

   assign gnt = r_gnt;
   assign s1  = r_sel[1];
   assign s0  = r_sel[0];

   mux4to1 u_mux (
      .s1 (r_sel[1]),
      .s0 (r_sel[0]),
      .i0 (i0),
      .i1 (i1),
      .i2 (i2),
      .i3 (i3),
      .y  (w_mux_y)
   );

   assign y = valid ? w_mux_y : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_sel_nxt   = r_sel;
      w_beats_nxt = r_beats;
      w_last_nxt  = r_last;
      w_rearb     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_rearb = 1'b1;
         end
         ST_GRANT: begin
            if (w_xfer) begin
               w_last_nxt  = r_sel;
               w_beats_nxt = w_beats_inc;
               if (w_beats_inc >= BEAT_W'(MAX_BEATS)) begin
                  w_rearb = 1'b1;
               end
            end else if (!w_req_g) begin
               w_last_nxt = r_sel;
               w_rearb    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase

      // A fresh winner gets a new grant directly; without one the arbiter parks in IDLE.
      if (w_rearb) begin
         if (w_pick[SEL_W]) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = w_pick_onehot;
            w_sel_nxt   = w_pick[SEL_W-1:0];
            w_beats_nxt = '0;
         end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_beats_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_sel   <= '0;
         r_beats <= '0;
         r_last  <= SEL_W'(NUM_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_sel   <= w_sel_nxt;
         r_beats <= w_beats_nxt;
         r_last  <= w_last_nxt;
      end
   end

endmodule
